fifo_wptr_full: RTL and testbench
=================================

Name: fifo_wptr_full

Overview:
Write-domain pointer and full-flag controller for the N-bit asynchronous FIFO. It is the sending end of the pointer crossing. It owns the binary write counter and issues a registered Gray-coded write pointer, which the read domain samples through its 2-flop synchronizer. It compares its next pointer against the already-synchronized read pointer to produce full, almost-full, fill level and overflow status. The block runs entirely on the write clock.

Parameters:
ADDR_WIDTH, 4, RAM address bits; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
AFULL_THRESH, 12, fill level at or above which walmost_full asserts (range 1..depth)

Ports:
clk  input  1  write-domain clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
winc  input  1  write request for this cycle
rptr_sync  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into clk domain
waddr  output  ADDR_WIDTH  RAM write address = low ADDR_WIDTH bits of the binary write counter
wen  output  1  RAM write enable = winc & ~wfull (combinational)
wptr  output  ADDR_WIDTH+1  registered Gray write pointer, to the read-side synchronizer
wfull  output  1  FIFO full, registered
walmost_full  output  1  level >= AFULL_THRESH, registered
wlevel  output  ADDR_WIDTH+1  write-side fill level 0..depth, registered (pessimistic)
woverflow  output  1  sticky flag: a write was attempted while full

Behaviour:
- Reset (rst=0, asynchronous): wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0. waddr=0 follows. Release is synchronous to clk, handled upstream.
- Accept rule: a write is accepted iff winc=1 and wfull=0 at the rising edge. wen is high in that cycle, and data is written at waddr on that edge.
- wbin_next = wbin + accept, modulo 2**(ADDR_WIDTH+1), with natural wrap.
- wgray_next = wbin_next ^ (wbin_next >> 1). wptr <= wgray_next each edge.
- wptr is driven only from a flop, never from logic. Consecutive wptr values differ in exactly one bit, including across the wrap.
- Latency: wptr, waddr, wlevel, wfull and walmost_full all reflect an accepted write on the edge that accepts it, i.e. visible in the next cycle.
- Full: wfull <= (wgray_next == {~rptr_sync[MSB:MSB-1], rptr_sync[MSB-2:0]}). This is Gray-domain equality with the top two bits inverted.
- Level: rbin = gray2bin(rptr_sync), a combinational XOR prefix. wlevel <= wbin_next - rbin, modulo 2**(ADDR_WIDTH+1). Its range is 0..depth.
- Almost full: walmost_full <= (wbin_next - rbin) >= AFULL_THRESH.
- Flag asymmetry: full and level are pessimistic, because rptr_sync lags the true read pointer by 2+ cycles.
  - Asserting wfull and walmost_full is immediate: they assert on the accepting edge.
  - Deasserting is delayed: they drop only after the read-pointer advance is visible on rptr_sync, one edge after that.
- Overflow: winc=1 while wfull=1 means the write is dropped. wbin, waddr and wptr do not change, and woverflow <= 1. woverflow stays set until reset.
- Simultaneous winc and rptr_sync advance while full: the write is dropped, because wfull was 1 at the edge. wfull recomputes to 0 on that edge. The next winc is accepted.
- rptr_sync must never be ahead of wptr. The block does not check this, and such input is undefined.
- Reset mid-operation clears all state immediately. Any in-flight write that cycle is lost.

Test Plan:
1. Reset, then rst=1, rptr_sync=0, winc=1 for 16 cycles (ADDR_WIDTH=4):
   - waddr steps 0..15.
   - wptr after write 16 = 5'b11000.
   - wfull=1 in the cycle after the 16th accept; wlevel=16.
   - walmost_full rises after the 12th accept.
2. Full, with winc=1 for 3 more cycles:
   - wen=0; wptr holds 11000; waddr holds 0.
   - woverflow=1 and stays 1 after winc drops.
3. Full, then rptr_sync=00001 (Gray 1):
   - wfull=0 and wlevel=15 one edge later.
   - The next winc is accepted, and wptr becomes Gray 17 = 11001.
4. Wrap: step rptr_sync along to keep the FIFO non-full, and write 40 words.
   - wptr goes 10000 (bin 31) -> 00000 (bin 0).
   - Every wptr transition toggles exactly one bit (bench-checked).
   - wlevel never exceeds 16.
5. Simultaneous event: full, with winc=1 in the same cycle rptr_sync advances.
   - That write is dropped (wen=0), and woverflow=1.
   - The following cycle's write is accepted.
6. Assert rst=0 mid-burst, asynchronously between edges:
   - wptr, wfull, wlevel, woverflow and waddr go to 0 immediately, without waiting for a clock edge.
   - After release, the first write lands at waddr=0.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Write-side pointer/flag controller for an async FIFO: owns the binary write
// counter, publishes a registered Gray pointer and derives full/level status.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_sync,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wen,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q, wovf_d;
  logic          accept;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rptr_full_cmp;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
    assign rbin[gi] = ^rptr_sync[PW-1:gi];
  end

  // Full when the next write pointer is exactly one lap ahead of the read pointer.
  assign rptr_full_cmp = {~rptr_sync[PW-1:PW-2], rptr_sync[PW-3:0]};

  always_comb begin
    accept   = winc & ~wfull_q;
    wbin_d   = wbin_q + {{(PW-1){1'b0}}, accept};
    wptr_d   = wbin_d ^ (wbin_d >> 1);
    wlevel_d = wbin_d - rbin;
    wfull_d  = (wptr_d == rptr_full_cmp);
    wafull_d = (wlevel_d >= AFULL_L);
    wovf_d   = wovf_q | (winc & wfull_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wen          = accept;
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Randomized bench for fifo_wptr_full against a counting model of writes/reads.
module tb_fifo_wptr_full;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int TH    = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          winc;
  logic [AW:0]   rptr_sync;
  logic [AW-1:0] waddr;
  logic          wen;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          woverflow;

  fifo_wptr_full #(.ADDR_WIDTH(AW), .AFULL_THRESH(TH)) dut (
    .clk(clk), .rst(rst), .winc(winc), .rptr_sync(rptr_sync),
    .waddr(waddr), .wen(wen), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: total accepted writes and total reads seen on rptr_sync, unbounded.
  int   m_wcnt, m_rcnt, m_level, txn;
  logic m_full, m_afull, m_ovf, last_acc;
  logic [AW:0] prev_wptr;

  function automatic logic [AW:0] gray(input int v);
    logic [AW:0] b;
    b = AW'(0) + v[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_rcnt = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ovf = 0; prev_wptr = '0;
  endtask

  // Called just after a rising edge; drives one cycle and checks both sides of the edge.
  task automatic step(input logic w, input int rc);
    winc      = w;
    m_rcnt    = rc;
    rptr_sync = gray(rc);
    #1;
    check("wen", 32'(wen), 32'(w && !m_full));
    check("waddr_pre", 32'(waddr), 32'(m_wcnt % DEPTH));
    @(posedge clk);
    last_acc = w && !m_full;
    if (w && m_full) m_ovf = 1'b1;
    if (last_acc) m_wcnt++;
    m_level = m_wcnt - m_rcnt;
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= TH);
    #1;
    check("waddr", 32'(waddr), 32'(m_wcnt % DEPTH));
    check("wptr", 32'(wptr), 32'(gray(m_wcnt)));
    check("wlevel", 32'(wlevel), 32'(m_level));
    check("wlevel_max", 32'(wlevel <= DEPTH), 32'd1);
    check("wfull", 32'(wfull), 32'(m_full));
    check("walmost_full", 32'(walmost_full), 32'(m_afull));
    check("woverflow", 32'(woverflow), 32'(m_ovf));
    check("wptr_onebit", 32'($countones(wptr ^ prev_wptr)), 32'(last_acc));
    prev_wptr = wptr;
    $display("txn %0d winc=%0b rptr=%05b acc=%0b waddr=%0d wptr=%05b lvl=%0d full=%0b af=%0b ovf=%0b",
             txn, w, rptr_sync, last_acc, waddr, wptr, wlevel, wfull, walmost_full, woverflow);
    txn++;
  endtask

  initial begin
    int acc_cnt, guard, lo, rc;
    txn = 0;
    rst = 1'b0; winc = 1'b0; rptr_sync = '0;
    model_reset();
    @(posedge clk); #1;
    check("rst_wptr", 32'(wptr), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wfull", 32'(wfull), 32'd0);
    check("rst_wlevel", 32'(wlevel), 32'd0);
    check("rst_ovf", 32'(woverflow), 32'd0);
    check("rst_afull", 32'(walmost_full), 32'd0);
    rst = 1'b1;

    // Fill with the read side idle.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 0);
    check("full_wptr_11000", 32'(wptr), 32'b11000);
    check("full_level16", 32'(wlevel), 32'd16);

    // Writes while full are dropped; overflow sticks.
    for (int i = 0; i < 3; i++) step(1'b1, 0);
    step(1'b0, 0);
    check("ovf_sticky", 32'(woverflow), 32'd1);

    // One read frees a slot; the next write goes in.
    step(1'b0, 1);
    check("free_level15", 32'(wlevel), 32'd15);
    step(1'b1, 1);
    check("wptr_gray17", 32'(wptr), 32'b11001);

    // Wrap the pointer while keeping the FIFO non-full.
    acc_cnt = 0; guard = 0;
    while (acc_cnt < 40 && guard < 200) begin
      lo = m_rcnt;
      if (m_wcnt - 14 > lo) lo = m_wcnt - 14;
      rc = lo + int'($urandom_range(0, m_wcnt - lo));
      step(($urandom_range(0, 4) != 0), rc);
      if (last_acc) acc_cnt++;
      guard++;
    end
    check("wrap_writes", 32'(acc_cnt), 32'd40);

    // Fill, then write in the same cycle the read pointer advances.
    guard = 0;
    while (!m_full && guard < 40) begin step(1'b1, m_rcnt); guard++; end
    check("filled", 32'(wfull), 32'd1);
    step(1'b1, m_rcnt + 1);
    check("simul_dropped", 32'(last_acc), 32'd0);
    step(1'b1, m_rcnt);
    check("simul_next_acc", 32'(last_acc), 32'd1);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      rc = m_rcnt;
      if ($urandom_range(0, 1) != 0) rc = m_rcnt + int'($urandom_range(0, m_wcnt - m_rcnt));
      step(($urandom_range(0, 3) != 0), rc);
    end

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 5; i++) step(1'b1, m_rcnt);
    winc = 1'b1;
    #3;
    rst = 1'b0;
    rptr_sync = '0;
    #1;
    model_reset();
    check("async_wptr", 32'(wptr), 32'd0);
    check("async_waddr", 32'(waddr), 32'd0);
    check("async_wfull", 32'(wfull), 32'd0);
    check("async_wlevel", 32'(wlevel), 32'd0);
    check("async_ovf", 32'(woverflow), 32'd0);
    #3;
    rst = 1'b1;
    step(1'b1, 0);
    check("post_rst_waddr", 32'(waddr), 32'd1);
    step(1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
